// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle between the feature-map feeder and the
// convolution stage. The feeder side is master; conv_window_gen is slave.
interface conv_window_gen_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int DIM_WIDTH       = 10,
  parameter int CONV_KERNEL_DIM = 3
);
  logic                                                  start_in;
  logic [DIM_WIDTH-1:0]                                  max_cols_in;
  logic [DIM_WIDTH-1:0]                                  max_rows_in;
  logic [DIM_WIDTH-1:0]                                  conv_size_in;
  logic [DATA_WIDTH-1:0]                                 pix_in;
  logic                                                  pix_valid_in;
  logic [CONV_KERNEL_DIM*CONV_KERNEL_DIM*DATA_WIDTH-1:0] window_out;
  logic                                                  window_valid_out;
  logic                                                  frame_done_out;
  logic                                                  busy_out;
  logic                                                  err_out;

  modport master (
    output start_in, max_cols_in, max_rows_in, conv_size_in, pix_in, pix_valid_in,
    input  window_out, window_valid_out, frame_done_out, busy_out, err_out
  );

  modport slave (
    input  start_in, max_cols_in, max_rows_in, conv_size_in, pix_in, pix_valid_in,
    output window_out, window_valid_out, frame_done_out, busy_out, err_out
  );
endinterface

// File: rtl/conv_window_gen.sv
// Line-buffer KxK window generator: turns a raster pixel stream of one
// pre-padded plane into flat windows for the convolution stage (3x3 or 1x1).
module conv_window_gen #(
  parameter int DATA_WIDTH      = 16,
  parameter int DIM_WIDTH       = 10,
  parameter int CONV_KERNEL_DIM = 3,
  parameter int MAX_COLS        = 418,
  parameter int CONV_DIM_3_3    = 9,
  parameter int CONV_DIM_1_1    = 1
) (
  input  logic            clk,
  input  logic            reset,
  conv_window_gen_if.slave bus
);
  localparam int K     = CONV_KERNEL_DIM;
  localparam int NSLOT = K * K;
  localparam int LB_AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  localparam logic [DIM_WIDTH-1:0] C_K    = DIM_WIDTH'(K);
  localparam logic [DIM_WIDTH-1:0] C_KM1  = DIM_WIDTH'(K - 1);
  localparam logic [DIM_WIDTH-1:0] C_KM2  = DIM_WIDTH'(K - 2);
  localparam logic [DIM_WIDTH-1:0] C_MAXC = DIM_WIDTH'(MAX_COLS);
  localparam logic [DIM_WIDTH-1:0] C_SZ3  = DIM_WIDTH'(CONV_DIM_3_3);
  localparam logic [DIM_WIDTH-1:0] C_SZ1  = DIM_WIDTH'(CONV_DIM_1_1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;
  state_t r_state, w_state_nxt;

  logic [DIM_WIDTH-1:0]        r_cols, r_rows, r_col, r_row;
  logic                        r_is3, r_valid, r_done, r_err;
  logic [NSLOT*DATA_WIDTH-1:0] r_win, w_win_nxt;
  // r_lb[j] holds row r-1-j; r_sh holds the K-1 previous window columns
  logic [DATA_WIDTH-1:0]       r_lb [K-1][MAX_COLS];
  logic [DATA_WIDTH-1:0]       r_sh [K][K-1];
  logic [DATA_WIDTH-1:0]       w_col_new [K];
  logic                        w_cfg_ok, w_start_ok, w_accept, w_col_last, w_row_last;
  logic                        w_last, w_emit;
  logic [LB_AW-1:0]            w_idx;

  assign w_cfg_ok   = ((bus.conv_size_in == C_SZ3) || (bus.conv_size_in == C_SZ1)) &&
                      (bus.max_cols_in <= C_MAXC) &&
                      (bus.max_cols_in != '0) && (bus.max_rows_in != '0) &&
                      !((bus.conv_size_in == C_SZ3) &&
                        ((bus.max_cols_in < C_K) || (bus.max_rows_in < C_K)));
  assign w_start_ok = bus.start_in && w_cfg_ok;
  assign w_accept   = (r_state != S_IDLE) && bus.pix_valid_in && !bus.start_in;
  assign w_col_last = (r_col == r_cols - 1'b1);
  assign w_row_last = (r_row == r_rows - 1'b1);
  assign w_last     = w_accept && w_col_last && w_row_last;
  assign w_emit     = w_accept && (!r_is3 || ((r_row >= C_KM1) && (r_col >= C_KM1)));
  assign w_idx      = r_col[LB_AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start_ok) begin
      w_state_nxt = (bus.conv_size_in == C_SZ3) ? S_FILL : S_RUN;
    end else begin
      case (r_state)
        S_FILL:  if (w_accept && (r_row == C_KM2) && w_col_last) w_state_nxt = S_RUN;
        S_RUN:   if (w_last) w_state_nxt = S_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_col_new = '{default: '0};
    w_col_new[K-1] = bus.pix_in;
    for (int unsigned j = 0; j < K - 1; j++) w_col_new[K-2-j] = r_lb[j][w_idx];
    w_win_nxt = '0;
    if (r_is3) begin
      for (int unsigned ky = 0; ky < K; ky++) begin
        for (int unsigned kx = 0; kx < K - 1; kx++)
          w_win_nxt[(ky*K+kx)*DATA_WIDTH +: DATA_WIDTH] = r_sh[ky][kx];
        w_win_nxt[(ky*K+K-1)*DATA_WIDTH +: DATA_WIDTH] = w_col_new[ky];
      end
    end else begin
      w_win_nxt[DATA_WIDTH-1:0] = bus.pix_in;
    end
  end

  // Storage without reset; stale contents are never observed because windows
  // are only emitted once K-1 rows and K-1 columns of the current frame exist.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][w_idx] <= bus.pix_in;
      for (int unsigned j = 1; j < K - 1; j++) r_lb[j][w_idx] <= r_lb[j-1][w_idx];
      for (int unsigned ky = 0; ky < K; ky++) begin
        for (int unsigned kx = 0; kx + 1 < K - 1; kx++) r_sh[ky][kx] <= r_sh[ky][kx+1];
        r_sh[ky][K-2] <= w_col_new[ky];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cols  <= '0;
      r_rows  <= '0;
      r_is3   <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_win   <= '0;
    end else begin
      r_valid <= w_emit;
      r_done  <= w_emit && w_last;
      if (w_emit) r_win <= w_win_nxt;
      if (w_start_ok) begin
        r_cols <= bus.max_cols_in;
        r_rows <= bus.max_rows_in;
        r_is3  <= (bus.conv_size_in == C_SZ3);
        r_col  <= '0;
        r_row  <= '0;
        r_err  <= 1'b0;
      end else begin
        if (bus.start_in || ((r_state == S_IDLE) && bus.pix_valid_in)) r_err <= 1'b1;
        if (w_accept) begin
          if (w_col_last) begin
            r_col <= '0;
            if (!w_row_last) r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end
    end
  end

  assign bus.window_out       = r_win;
  assign bus.window_valid_out = r_valid;
  assign bus.frame_done_out   = r_done;
  assign bus.busy_out         = (r_state != S_IDLE);
  assign bus.err_out          = r_err;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: config table, fixed frames, restart/reset/error
// sequences and randomized frames against an image-array reference model.
module tb_conv_window_gen;
  localparam int DW = 16, DIMW = 10, K = 3, MAXC = 418, NS = K * K, WW = NS * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_window_gen_if #(.DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .CONV_KERNEL_DIM(K)) bus ();

  conv_window_gen #(
    .DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .CONV_KERNEL_DIM(K), .MAX_COLS(MAXC),
    .CONV_DIM_3_3(9), .CONV_DIM_1_1(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the frame as a 2-D image plus the latched config
  logic [DW-1:0] img [0:15][0:15];
  int            m_cols, m_rows;
  bit            m_is3;
  logic [WW-1:0] hold_win;
  int            win_cnt;
  bit            got_first;
  logic [WW-1:0] first_win, last_win;

  typedef struct {
    int cols;
    int rows;
    int size;
    bit err;
    bit busy;
  } cfg_vec_t;
  cfg_vec_t tbl [12];

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] ref_window(input int r, input int c);
    logic [WW-1:0] w = '0;
    if (m_is3) begin
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          w[(ky*3+kx)*DW +: DW] = img[r-2+ky][c-2+kx];
    end else begin
      w[DW-1:0] = img[r][c];
    end
    return w;
  endfunction

  task automatic step_check(input bit ev, input bit ed, input logic [WW-1:0] ew);
    tick();
    if (ev) hold_win = ew;
    chk("window_valid", WW'(bus.window_valid_out), WW'(ev));
    chk("frame_done", WW'(bus.frame_done_out), WW'(ed));
    chk("window", bus.window_out, hold_win);
    if (bus.window_valid_out) begin
      win_cnt++;
      if (!got_first) first_win = bus.window_out;
      got_first = 1'b1;
      last_win = bus.window_out;
    end
  endtask

  task automatic clr_stats();
    win_cnt   = 0;
    got_first = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start_in = 1'b0;
    bus.pix_valid_in = 1'b0;
    tick();
    reset = 1'b0;
    hold_win = '0;
  endtask

  task automatic start_cfg(input int cols, input int rows, input int size,
                           input bit with_pix, input logic [DW-1:0] pv);
    bus.max_cols_in  = DIMW'(cols);
    bus.max_rows_in  = DIMW'(rows);
    bus.conv_size_in = DIMW'(size);
    bus.start_in     = 1'b1;
    bus.pix_valid_in = with_pix;
    bus.pix_in       = pv;
    m_cols = cols;
    m_rows = rows;
    m_is3  = (size == 9);
    step_check(1'b0, 1'b0, '0);
    bus.start_in     = 1'b0;
    bus.pix_valid_in = 1'b0;
    bus.max_cols_in  = '1;
    bus.max_rows_in  = '1;
    bus.conv_size_in = '0;
  endtask

  task automatic send_pixels(input int limit, input int base, input bit rnd, input int max_gap);
    int total, lim, r, c, g;
    logic [DW-1:0] v;
    bit ev;
    total = m_cols * m_rows;
    lim   = (limit < total) ? limit : total;
    for (int n = 0; n < lim; n++) begin
      r = n / m_cols;
      c = n % m_cols;
      v = rnd ? DW'($urandom) : DW'(base + n);
      img[r][c] = v;
      bus.pix_in = v;
      bus.pix_valid_in = 1'b1;
      ev = m_is3 ? (r >= 2 && c >= 2) : 1'b1;
      step_check(ev, n == total - 1, ev ? ref_window(r, c) : '0);
      bus.pix_valid_in = 1'b0;
      bus.pix_in = DW'($urandom);
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) step_check(1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int fv [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    logic [WW-1:0] exp_first;
    int cols, rows;
    bit is3;

    tbl[0]  = '{5, 5, 9, 1'b0, 1'b1};
    tbl[1]  = '{5, 5, 4, 1'b1, 1'b0};
    tbl[2]  = '{5, 5, 1, 1'b0, 1'b1};
    tbl[3]  = '{2, 5, 9, 1'b1, 1'b0};
    tbl[4]  = '{5, 2, 9, 1'b1, 1'b0};
    tbl[5]  = '{1, 1, 1, 1'b0, 1'b1};
    tbl[6]  = '{0, 3, 1, 1'b1, 1'b0};
    tbl[7]  = '{3, 0, 1, 1'b1, 1'b0};
    tbl[8]  = '{418, 3, 9, 1'b0, 1'b1};
    tbl[9]  = '{419, 3, 9, 1'b1, 1'b0};
    tbl[10] = '{3, 3, 9, 1'b0, 1'b1};
    tbl[11] = '{2, 2, 1, 1'b0, 1'b1};

    reset = 1'b1;
    bus.start_in = 1'b0;
    bus.pix_valid_in = 1'b0;
    bus.pix_in = '0;
    bus.max_cols_in = '0;
    bus.max_rows_in = '0;
    bus.conv_size_in = '0;
    hold_win = '0;
    clr_stats();
    tick();
    tick();
    chk("rst_window", bus.window_out, '0);
    chk("rst_valid", WW'(bus.window_valid_out), '0);
    chk("rst_done", WW'(bus.frame_done_out), '0);
    chk("rst_busy", WW'(bus.busy_out), '0);
    chk("rst_err", WW'(bus.err_out), '0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      do_reset();
      start_cfg(tbl[i].cols, tbl[i].rows, tbl[i].size, 1'b0, '0);
      chk($sformatf("cfg%0d_err", i), WW'(bus.err_out), WW'(tbl[i].err));
      chk($sformatf("cfg%0d_busy", i), WW'(bus.busy_out), WW'(tbl[i].busy));
    end

    // 3x3 5x5 gapless, pix = r*5+c
    do_reset();
    clr_stats();
    start_cfg(5, 5, 9, 1'b0, '0);
    send_pixels(25, 0, 1'b0, 0);
    exp_first = '0;
    for (int i = 0; i < 9; i++) exp_first[i*DW +: DW] = DW'(fv[i]);
    chk("g_count", WW'(win_cnt), WW'(9));
    chk("g_first", first_win, exp_first);
    chk("g_last_s0", WW'(last_win[DW-1:0]), WW'(12));
    chk("g_last_s8", WW'(last_win[8*DW +: DW]), WW'(24));
    chk("g_busy_end", WW'(bus.busy_out), '0);

    // 1x1 4x2
    clr_stats();
    start_cfg(4, 2, 1, 1'b0, '0);
    send_pixels(8, 0, 1'b0, 0);
    chk("p_count", WW'(win_cnt), WW'(8));
    chk("p_last", last_win, WW'(7));

    // 5x5 with random gaps
    clr_stats();
    start_cfg(5, 5, 9, 1'b0, '0);
    send_pixels(25, 0, 1'b0, 3);
    chk("gap_count", WW'(win_cnt), WW'(9));
    chk("gap_first", first_win, exp_first);

    // Restart after 13 pixels, pixel coincident with start dropped
    start_cfg(5, 5, 9, 1'b0, '0);
    send_pixels(13, 100, 1'b0, 0);
    clr_stats();
    start_cfg(5, 5, 9, 1'b1, 16'd999);
    send_pixels(25, 200, 1'b0, 0);
    chk("rs_count", WW'(win_cnt), WW'(9));
    chk("rs_first_s0", WW'(first_win[DW-1:0]), WW'(200));
    chk("rs_last_s8", WW'(last_win[8*DW +: DW]), WW'(224));

    // Reset mid-frame after 7 pixels
    start_cfg(5, 5, 9, 1'b0, '0);
    send_pixels(7, 300, 1'b0, 0);
    reset = 1'b1;
    tick();
    chk("mr_window", bus.window_out, '0);
    chk("mr_valid", WW'(bus.window_valid_out), '0);
    chk("mr_done", WW'(bus.frame_done_out), '0);
    chk("mr_busy", WW'(bus.busy_out), '0);
    chk("mr_err", WW'(bus.err_out), '0);
    reset = 1'b0;
    hold_win = '0;
    clr_stats();
    for (int i = 0; i < 18; i++) begin
      bus.pix_valid_in = 1'b1;
      bus.pix_in = DW'($urandom);
      step_check(1'b0, 1'b0, '0);
    end
    bus.pix_valid_in = 1'b0;
    chk("mr_nowin", WW'(win_cnt), '0);
    chk("mr_err_idle_pix", WW'(bus.err_out), WW'(1));
    start_cfg(5, 5, 9, 1'b0, '0);
    send_pixels(25, 400, 1'b0, 0);
    chk("mr_new_count", WW'(win_cnt), WW'(9));

    // Error cases from IDLE
    start_cfg(5, 5, 4, 1'b0, '0);
    chk("e_size_err", WW'(bus.err_out), WW'(1));
    chk("e_size_busy", WW'(bus.busy_out), '0);
    do_reset();
    bus.pix_valid_in = 1'b1;
    bus.pix_in = 16'h1234;
    step_check(1'b0, 1'b0, '0);
    bus.pix_valid_in = 1'b0;
    step_check(1'b0, 1'b0, '0);
    chk("e_pix_err", WW'(bus.err_out), WW'(1));
    start_cfg(3, 3, 9, 1'b0, '0);
    chk("e_clear_err", WW'(bus.err_out), '0);
    chk("e_clear_busy", WW'(bus.busy_out), WW'(1));
    clr_stats();
    send_pixels(9, 500, 1'b0, 0);
    chk("e_3x3_count", WW'(win_cnt), WW'(1));

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      is3  = bit'($urandom_range(0, 1));
      cols = is3 ? int'($urandom_range(3, 8)) : int'($urandom_range(1, 8));
      rows = is3 ? int'($urandom_range(3, 6)) : int'($urandom_range(1, 6));
      clr_stats();
      start_cfg(cols, rows, is3 ? 9 : 1, bit'($urandom_range(0, 1)), DW'($urandom));
      send_pixels(cols * rows, 0, 1'b1, 3);
      chk($sformatf("rnd%0d_count", f), WW'(win_cnt),
          WW'(is3 ? (rows - 2) * (cols - 2) : rows * cols));
      chk($sformatf("rnd%0d_busy", f), WW'(bus.busy_out), '0);
      chk($sformatf("rnd%0d_err", f), WW'(bus.err_out), '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
